// File: rtl/fizz_buzz_stream.sv
// fizz_buzz_stream: steps a count from 0 to a programmable limit and emits one
// valid/ready beat per count value. Each beat carries a per-channel divisibility
// flag, tracked with residue counters so no divider is needed.
module fizz_buzz_stream #(
    parameter int unsigned NUM_DIV = 2,
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [NUM_DIV*DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0]         cfg_limit,
    input  logic                     cfg_wrap,
    input  logic                     start,
    input  logic                     stop,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         out_count,
    output logic [NUM_DIV-1:0]       out_hit,
    output logic                     out_all,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [DIV_W-1:0]   r_div [NUM_DIV];
    logic [DIV_W-1:0]   r_res [NUM_DIV];
    logic [CNT_W-1:0]   r_limit;
    logic               r_wrap;
    logic [CNT_W-1:0]   r_count;
    logic               r_done;

    logic               w_run;
    logic               w_cfg_acc;
    logic               w_start;
    logic               w_stop;
    logic               w_xfer;
    logic               w_last;
    logic [NUM_DIV-1:0] w_hit;
    logic [NUM_DIV-1:0] w_en;

    // Handshake qualifiers; stop wins over a same-cycle transfer
    assign w_run     = (r_state == S_RUN);
    assign w_cfg_acc = cfg_valid && !w_run;
    assign w_start   = start && !w_run;
    assign w_stop    = stop && w_run;
    assign w_xfer    = w_run && out_ready && !stop;
    assign w_last    = (r_count == r_limit);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_xfer && w_last && !r_wrap) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Configuration capture; only accepted outside a run
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_limit <= '0;
            r_wrap  <= 1'b0;
            for (int i = 0; i < int'(NUM_DIV); i++) begin
                r_div[i] <= '0;
            end
        end else if (w_cfg_acc) begin
            r_limit <= cfg_limit;
            r_wrap  <= cfg_wrap;
            for (int i = 0; i < int'(NUM_DIV); i++) begin
                r_div[i] <= cfg_div[i*DIV_W +: DIV_W];
            end
        end
    end

    // Count and residue stepping on each accepted beat
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= '0;
            for (int i = 0; i < int'(NUM_DIV); i++) begin
                r_res[i] <= '0;
            end
        end else if (w_start) begin
            r_count <= '0;
            for (int i = 0; i < int'(NUM_DIV); i++) begin
                r_res[i] <= '0;
            end
        end else if (w_xfer) begin
            if (!w_last) begin
                r_count <= r_count + CNT_W'(1);
                for (int i = 0; i < int'(NUM_DIV); i++) begin
                    if (r_res[i] == r_div[i] - DIV_W'(1)) begin
                        r_res[i] <= '0;
                    end else begin
                        r_res[i] <= r_res[i] + DIV_W'(1);
                    end
                end
            end else if (r_wrap) begin
                r_count <= '0;
                for (int i = 0; i < int'(NUM_DIV); i++) begin
                    r_res[i] <= '0;
                end
            end
        end
    end

    // Sticky completion flag for one-shot runs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_done <= 1'b0;
        end else if (w_cfg_acc || w_start || w_stop) begin
            r_done <= 1'b0;
        end else if (w_xfer && w_last && !r_wrap) begin
            r_done <= 1'b1;
        end
    end

    // Hit decode straight from the registered residues
    always_comb begin
        w_hit = '0;
        w_en  = '0;
        for (int i = 0; i < int'(NUM_DIV); i++) begin
            w_en[i]  = (r_div[i] != '0);
            w_hit[i] = w_en[i] && (r_res[i] == '0);
        end
    end

    assign out_valid = w_run;
    assign out_count = r_count;
    assign out_hit   = w_hit;
    assign out_all   = (|w_en) && (&(w_hit | ~w_en));
    assign busy      = w_run;
    assign done      = r_done;
    assign cfg_ready = !w_run;

endmodule

// File: tb/tb_fizz_buzz_stream.sv
// Directed bench for fizz_buzz_stream: one-shot, backpressure, wrap, abort,
// config gating, divisor edge cases and mid-run reset.
module tb_fizz_buzz_stream;

    localparam int unsigned NUM_DIV = 2;
    localparam int unsigned DIV_W   = 8;
    localparam int unsigned CNT_W   = 8;

    logic                     clk = 1'b0;
    logic                     resetn;
    logic                     cfg_valid;
    logic                     cfg_ready;
    logic [NUM_DIV*DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0]         cfg_limit;
    logic                     cfg_wrap;
    logic                     start;
    logic                     stop;
    logic                     out_valid;
    logic                     out_ready;
    logic [CNT_W-1:0]         out_count;
    logic [NUM_DIV-1:0]       out_hit;
    logic                     out_all;
    logic                     busy;
    logic                     done;

    int n_cmp = 0;
    int n_err = 0;

    fizz_buzz_stream #(
        .NUM_DIV (NUM_DIV),
        .DIV_W   (DIV_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_limit (cfg_limit),
        .cfg_wrap  (cfg_wrap),
        .start     (start),
        .stop      (stop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_hit   (out_hit),
        .out_all   (out_all),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected beat contents for a count value under divisors d0/d1
    task automatic check_beat(input string tag, input int cnt, input int d0, input int d1);
        logic h0, h1, all;
        h0  = (d0 != 0) && ((cnt % d0) == 0);
        h1  = (d1 != 0) && ((cnt % d1) == 0);
        all = ((d0 != 0) || (d1 != 0)) && ((d0 == 0) || h0) && ((d1 == 0) || h1);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_count"}, 32'(out_count), 32'(cnt));
        check_eq({tag, "_hit"},   32'(out_hit),   32'({h1, h0}));
        check_eq({tag, "_all"},   32'(out_all),   32'(all));
    endtask

    task automatic offer_cfg(input int d0, input int d1, input int lim, input logic wrap);
        cfg_valid = 1'b1;
        cfg_div   = {8'(d1), 8'(d0)};
        cfg_limit = 8'(lim);
        cfg_wrap  = wrap;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_count"}, 32'(out_count), 32'd0);
        check_eq({tag, "_hit"},   32'(out_hit),   32'd0);
        check_eq({tag, "_all"},   32'(out_all),   32'd0);
        check_eq({tag, "_busy"},  32'(busy),      32'd0);
        check_eq({tag, "_done"},  32'(done),      32'd0);
        check_eq({tag, "_cfgrdy"}, 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic rdy;

        resetn    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_limit = '0;
        cfg_wrap  = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        out_ready = 1'b1;

        // Reset state
        tick;
        tick;
        check_idle_outputs("reset");
        resetn = 1'b1;
        tick;

        // Basic one-shot: divisors 3/5, counts 0..15
        offer_cfg(3, 5, 15, 1'b0);
        start = 1'b1;
        tick;
        cfg_valid = 1'b0;
        start     = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check_beat("oneshot", k, 3, 5);
            tick;
        end
        check_eq("oneshot_end_valid", 32'(out_valid), 32'd0);
        check_eq("oneshot_end_done",  32'(done),      32'd1);
        check_eq("oneshot_end_busy",  32'(busy),      32'd0);

        // Backpressure: same sequence with random stalls
        start = 1'b1;
        tick;
        start = 1'b0;
        e = 0;
        for (int cyc = 0; cyc < 400 && e < 16; cyc++) begin
            rdy       = 1'($urandom_range(0, 1));
            out_ready = rdy;
            check_beat("bp", e, 3, 5);
            tick;
            if (rdy) e++;
        end
        out_ready = 1'b1;
        check_eq("bp_beats",     32'(e),         32'd16);
        check_eq("bp_end_valid", 32'(out_valid), 32'd0);
        check_eq("bp_end_done",  32'(done),      32'd1);

        // Wrap with channel 1 disabled
        offer_cfg(2, 0, 4, 1'b1);
        start = 1'b1;
        tick;
        cfg_valid = 1'b0;
        start     = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check_beat("wrap", k % 5, 2, 0);
            check_eq("wrap_done", 32'(done), 32'd0);
            tick;
        end
        stop = 1'b1;
        tick;
        stop = 1'b0;
        check_eq("wrap_stop_busy",  32'(busy),      32'd0);
        check_eq("wrap_stop_valid", 32'(out_valid), 32'd0);

        // Abort at count 7 while stalled
        offer_cfg(3, 5, 15, 1'b0);
        start = 1'b1;
        tick;
        cfg_valid = 1'b0;
        start     = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check_beat("abort_pre", k, 3, 5);
            tick;
        end
        check_beat("abort_at7", 7, 3, 5);
        out_ready = 1'b0;
        stop      = 1'b1;
        tick;
        stop      = 1'b0;
        out_ready = 1'b1;
        check_eq("abort_valid",  32'(out_valid), 32'd0);
        check_eq("abort_busy",   32'(busy),      32'd0);
        check_eq("abort_done",   32'(done),      32'd0);
        check_eq("abort_cfgrdy", 32'(cfg_ready), 32'd1);
        start = 1'b1;
        tick;
        start = 1'b0;
        check_beat("restart", 0, 3, 5);

        // Config offered mid-run is refused and leaves the run alone
        tick;
        check_beat("gate", 1, 3, 5);
        offer_cfg(1, 200, 9, 1'b0);
        #1;
        check_eq("gate_cfgrdy", 32'(cfg_ready), 32'd0);
        tick;
        cfg_valid = 1'b0;
        for (int k = 2; k < 16; k++) begin
            check_beat("gate_run", k, 3, 5);
            tick;
        end
        check_eq("gate_end_valid", 32'(out_valid), 32'd0);
        check_eq("gate_end_done",  32'(done),      32'd1);

        // div=1 hits everywhere, div=200 only at count 0
        offer_cfg(1, 200, 9, 1'b0);
        start = 1'b1;
        tick;
        cfg_valid = 1'b0;
        start     = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check_beat("edge", k, 1, 200);
            tick;
        end
        check_eq("edge_end_valid", 32'(out_valid), 32'd0);
        check_eq("edge_end_done",  32'(done),      32'd1);

        // Reset mid-run at count 5 wipes config too
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_beat("rst_pre", k, 1, 200);
            tick;
        end
        check_beat("rst_at5", 5, 1, 200);
        resetn = 1'b0;
        tick;
        check_idle_outputs("midrst");
        resetn = 1'b1;
        start  = 1'b1;
        tick;
        start = 1'b0;
        check_beat("postrst", 0, 0, 0);
        tick;
        check_eq("postrst_valid", 32'(out_valid), 32'd0);
        check_eq("postrst_done",  32'(done),      32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fizz_buzz_stream.md
Name: fizz_buzz_stream

Overview:
- Multi-channel modulo event generator: steps a count from 0 to a programmable limit.
- Emits one output beat per count value, carrying a per-channel "divisible" flag for each programmable divisor.
- Uses per-channel residue counters; no divider or modulo hardware.
- Sits on a valid/ready stream, so downstream can stall it. Supports one-shot and wrap modes plus abort.

Parameters:
- NUM_DIV, 2, number of divisor channels (>=1).
- DIV_W, 8, width of each divisor and residue counter.
- CNT_W, 8, width of the count and the limit.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration accepted when high (combinational: state != RUN).
- cfg_div  in  NUM_DIV*DIV_W  divisors; channel i at [i*DIV_W +: DIV_W]; 0 disables the channel.
- cfg_limit  in  CNT_W  last count value, inclusive.
- cfg_wrap  in  1  1 = restart at 0 after the limit; 0 = stop.
- start  in  1  begin a run.
- stop  in  1  abort a run.
- out_valid  out  1  beat present.
- out_ready  in  1  downstream accepts the beat.
- out_count  out  CNT_W  current count.
- out_hit  out  NUM_DIV  bit i = channel i enabled and count divisible by div[i].
- out_all  out  1  AND of out_hit over enabled channels; 0 if no channel is enabled.
- busy  out  1  state == RUN.
- done  out  1  sticky: a one-shot run completed.

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. On reset, state=IDLE and all config registers are 0 (divisors, limit, wrap). Count=0, residues=0. Output reset values: out_valid=0, out_count=0, out_hit=0, out_all=0, busy=0, done=0, cfg_ready=1.
- States: IDLE, RUN, DONE.
- Config: when cfg_valid&&cfg_ready, latch cfg_div, cfg_limit and cfg_wrap; done clears. In RUN, cfg_ready=0 and offers are ignored.
- Start: start in IDLE/DONE -> next cycle RUN, count=0, all residues=0, out_valid=1, done=0.
  - start in RUN is ignored.
  - If a config handshake and start occur in the same cycle, the run uses the new config.
- Transfer: a beat transfers on out_valid&&out_ready. While out_valid&&!out_ready, out_count, out_hit and out_all stay stable.
- After a transfer:
  - If count != limit: count+1. Each residue r_i <= (r_i == div_i-1) ? 0 : r_i+1.
  - If count == limit and wrap=1: count=0, residues=0, run continues with no gap cycle.
  - If count == limit and wrap=0: out_valid=0, state DONE, done=1.
- Hit decode: out_hit[i] = (div_i != 0) && (r_i == 0). It is decoded from registered count/residues, so output latency is zero relative to the count register.
- Edge cases:
  - div=1 hits every count.
  - div > limit hits only at count 0.
  - limit=0 gives a single beat (count 0), or a continuous stream of count-0 beats when wrap=1.
- Stop: stop in RUN -> next cycle IDLE, out_valid=0, done=0.
  - stop has priority over a same-cycle transfer; that beat counts as not accepted.
  - stop outside RUN is ignored.
- Reset mid-run: returns everything to reset values; config is lost.
- Width: count compares to limit exactly; count never exceeds limit, so there is no CNT_W overflow.

Test Plan:
- Basic one-shot: div{ch0=3,ch1=5}, limit=15, wrap=0, out_ready=1, start.
  - Required: 16 beats with counts 0..15; hit0 at 0,3,6,9,12,15; hit1 at 0,5,10,15; out_all at 0 and 15.
  - Then out_valid=0, done=1, busy=0.
- Backpressure: same config with out_ready randomised.
  - Required: identical accepted sequence, with no beat lost or duplicated.
  - Outputs held stable on every stalled cycle.
- Wrap and disabled channel: div{2,0}, limit=4, wrap=1, run 12 beats.
  - Required: counts 0,1,2,3,4,0,1,...; hit0 at 0,2,4; hit1 never; out_all==hit0; done stays 0.
- Abort: stop asserted at count 7 while out_ready=0.
  - Required: next cycle out_valid=0, busy=0, done=0.
  - cfg_ready=1. A new start restarts at count 0 with residues 0.
- Config gating and edge cases:
  - cfg_valid during RUN -> cfg_ready=0 and the run is unchanged.
  - Then cfg div{1,200}, limit=9: hit0 on all 10 beats; hit1 only at count 0.
- Reset mid-run at count 5.
  - Required: all outputs at reset values next cycle.
  - A following start with no new config yields one beat, count 0, out_hit=0, out_all=0, then done=1.
